// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: instruction-memory read channel, redirect/stall inputs
// and the registered instruction presented to decode.
interface if_fetch_if #(
    parameter int unsigned ADDR_W = 64
);
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 7;

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_rvalid;
    logic [INSTR_W-1:0]  imem_rdata;
    logic                stall;
    logic                branch_taken;
    logic [ADDR_W-1:0]   branch_target;
    logic [ADDR_W-1:0]   pc;
    logic                if_valid;
    logic [INSTR_W-1:0]  if_instr;
    logic [ADDR_W-1:0]   if_pc;
    logic [OPC_W-1:0]    if_opcode;

    modport master (
        output imem_req, imem_addr, pc, if_valid, if_instr, if_pc, if_opcode,
        input  imem_rvalid, imem_rdata, stall, branch_taken, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, pc, if_valid, if_instr, if_pc, if_opcode,
        output imem_rvalid, imem_rdata, stall, branch_taken, branch_target
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: one outstanding imem read, registered instruction
// for decode, branch redirect with squash of the in-flight response.
module if_fetch_stage #(
    parameter int unsigned        ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    if_fetch_if.master   bus
);
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 7;

    typedef enum logic [2:0] {
        BOOT    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        HOLD    = 3'd3,
        DISCARD = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic                 valid_q, valid_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]    ipc_q, ipc_d;
    logic [ADDR_W-1:0]    redirect_pc;

    assign redirect_pc = {bus.branch_target[ADDR_W-1:2], 2'b00};

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    // Next-state and datapath update; redirect overrides everything but BOOT
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;

        unique case (state_q)
            BOOT:  state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.imem_rvalid) begin
                    instr_d = bus.imem_rdata;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!bus.stall) begin
                    valid_d = 1'b0;
                    pc_d    = ADDR_W'(pc_q + ADDR_W'(4));
                    state_d = ISSUE;
                end
            end
            DISCARD: begin
                if (bus.imem_rvalid) state_d = ISSUE;
            end
            default: state_d = BOOT;
        endcase

        if (bus.branch_taken && (state_q != BOOT)) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            instr_d = instr_q;
            ipc_d   = ipc_q;
            unique case (state_q)
                ISSUE:   state_d = DISCARD;
                WAIT:    state_d = bus.imem_rvalid ? ISSUE : DISCARD;
                HOLD:    state_d = ISSUE;
                DISCARD: state_d = DISCARD;
                default: state_d = state_q;
            endcase
        end
    end

    // Request is a pure decode of the state register
    assign bus.imem_req  = (state_q == ISSUE);
    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.if_valid  = valid_q;
    assign bus.if_instr  = instr_q;
    assign bus.if_pc     = ipc_q;
    assign bus.if_opcode = instr_q[OPC_W-1:0];

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage for the RV64-style datapath. Holds the program counter, issues one instruction-memory read at a time, and registers the returned word plus its PC for the decode/control stage, which consumes `if_opcode`. Taken branches from the execute stage redirect the PC and squash any fetch in flight. Downstream back-pressure is applied through `stall`.

## Interface
- `ADDR_W`, 64, PC and memory address width
- `RESET_PC`, 64'h0, PC loaded on reset

- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `imem_req`  out  1  read request, one-cycle pulse
- `imem_addr`  out  ADDR_W  read address, valid while `imem_req`=1
- `imem_rvalid`  in  1  read data valid, one-cycle pulse
- `imem_rdata`  in  32  instruction word
- `stall`  in  1  decode cannot accept; hold current instruction
- `branch_taken`  in  1  redirect request, single-cycle pulse (Branch & zero)
- `branch_target`  in  ADDR_W  redirect address
- `pc`  out  ADDR_W  next fetch address
- `if_valid`  out  1  `if_instr`/`if_pc` hold a live instruction
- `if_instr`  out  32  fetched instruction
- `if_pc`  out  ADDR_W  address of `if_instr`
- `if_opcode`  out  7  `if_instr[6:0]`, wired to control

## Operation
- States: BOOT, ISSUE, WAIT, HOLD, DISCARD.
- `imem_req` = (state==ISSUE); `imem_addr` = `pc`. Both are decoded from the state and are not registered separately.
- BOOT: reset state; no request. BOOT -> ISSUE unconditionally.
- ISSUE: request at `pc`. ISSUE -> WAIT.
- WAIT: on `imem_rvalid`, capture `if_instr`<=`imem_rdata`, `if_pc`<=`pc`, `if_valid`<=1, then go to HOLD. Otherwise stay.
- HOLD: if `stall`=0, the instruction is consumed this cycle: `if_valid`<=0, `pc`<=`pc`+4, go to ISSUE. If `stall`=1, all outputs stay frozen.
- DISCARD: one response is still owed. Drop the next `imem_rvalid` without capturing it, then go to ISSUE.
- Redirect (`branch_taken`=1) overrides all transitions in the same cycle:
  - `pc`<=`{branch_target[ADDR_W-1:2],2'b00}`, `if_valid`<=0.
  - From ISSUE, or from WAIT without `imem_rvalid`: go to DISCARD.
  - From WAIT with `imem_rvalid`: the response is dropped; go to ISSUE.
  - From HOLD or DISCARD: HOLD -> ISSUE; DISCARD stays DISCARD.
  - From BOOT: the redirect is ignored.
  - Redirect wins over `stall`.
- `imem_rvalid` in BOOT, ISSUE or HOLD is spurious and ignored. There is never more than one outstanding request.
- `pc`+4 wraps modulo 2^ADDR_W.

## Timing
- Reset values: state=BOOT, `pc`=RESET_PC, `if_valid`=0, `if_instr`=0, `if_pc`=0, `imem_req`=0.
- Reset asserted mid-fetch aborts immediately. A response arriving after reset release, while in BOOT, is ignored.
- Zero-wait memory (rvalid one cycle after the request):
  - ISSUE at cycle t, rvalid at t+1, `if_valid`=1 at t+2.
  - Consumed at t+2 if no stall; next ISSUE at t+3.
  - Throughput is 1 instruction per 3 cycles.
- Each memory wait cycle adds one cycle of latency.
- Redirect latency: `branch_taken` at cycle t gives `pc`=target at t+1. The ISSUE of the target is at t+1, or one cycle after the owed response when passing through DISCARD.
- `if_opcode` changes only when `if_instr` changes.

## Test plan
- Reset release, RESET_PC=0, 1-cycle memory returning 0x00000033 @0, 0x00003003 @4 -> `imem_addr` 0 then 4; `if_opcode` 0x33 then 0x03; `if_pc` 0 then 4; `if_valid` high one cycle each.
- `stall`=1 for 5 cycles while in HOLD with `if_instr`=0x00003003 -> outputs frozen, `imem_req`=0 throughout; the next request at `pc`=8 is issued the cycle after `stall` falls.
- `branch_taken` with target 0x40 in the same cycle as ISSUE @8 -> enter DISCARD; the response for 8 is never visible; next request at 0x40; `if_pc`=0x40.
- `branch_taken` with target 0x83 coincident with `imem_rvalid` in WAIT -> response dropped, `if_valid`=0, next request at 0x80.
- Spurious `imem_rvalid` in HOLD with `stall`=1, then `rst_n` low mid-WAIT -> spurious pulse ignored; after reset `pc`=RESET_PC, `if_valid`=0, first request one cycle after release.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second fetch at address 0.
